// File: rtl/frame_buffer_scanout.sv
// Scanout side of the double-buffered framebuffer: raster timing generator,
// burst prefetch of the displayed buffer into a pixel FIFO, one pixel per pixel enable.
module frame_buffer_scanout #(
   parameter int          H_ACTIVE   = 160,
   parameter int          H_FP       = 8,
   parameter int          H_SYNC     = 16,
   parameter int          H_TOTAL    = 200,
   parameter int          V_ACTIVE   = 120,
   parameter int          V_FP       = 2,
   parameter int          V_SYNC     = 2,
   parameter int          V_TOTAL    = 130,
   parameter int          PIX_DIV    = 4,
   parameter int          FIFO_DEPTH = 64,
   parameter int          BURST_LEN  = 16,
   parameter logic [31:0] FB_BASE0   = 32'h0000_0000,
   parameter logic [31:0] FB_BASE1   = 32'h0000_8000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flip,
   output logic        rd_req_valid,
   input  logic        rd_req_ready,
   output logic [31:0] rd_req_addr,
   output logic [7:0]  rd_req_len,
   input  logic        rd_data_valid,
   input  logic [31:0] rd_data,
   output logic        hsync,
   output logic        vsync,
   output logic        de,
   output logic [23:0] rgb,
   output logic        underflow
);

   localparam int TOTAL_PIX = H_ACTIVE * V_ACTIVE;
   localparam int H_W       = $clog2(H_TOTAL + 1);
   localparam int V_W       = $clog2(V_TOTAL + 1);
   localparam int DIV_W     = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int CRD_W     = CNT_W + 2;
   localparam int FETCH_W   = 17;

   typedef enum logic {S_IDLE, S_REQ} fetch_state_t;

   fetch_state_t       state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [H_W-1:0]     h_q, h_d;
   logic [V_W-1:0]     v_q, v_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               de_q, de_d;
   logic [23:0]        rgb_q, rgb_d;
   logic               underflow_q, underflow_d;
   logic               disp_sel_q, disp_sel_d;
   logic [FETCH_W-1:0] fetch_q, fetch_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               req_valid_q, req_valid_d;
   logic [31:0]        req_addr_q, req_addr_d;
   logic [23:0]        fifo_mem_q [FIFO_DEPTH];

   logic               pe, visible, hs_win, vs_win, latch;
   logic               fifo_empty, push, pop, rsp_accept, req_fire;
   logic               fetch_more, credit_ok;
   logic [CRD_W-1:0]   credit_sum;
   logic               rd_data_unused;

   assign rd_data_unused = ^rd_data[31:24];

   assign pe      = (div_q == DIV_W'(PIX_DIV - 1));
   assign visible = (h_q < H_W'(H_ACTIVE)) && (v_q < V_W'(V_ACTIVE));
   assign hs_win  = (h_q >= H_W'(H_ACTIVE + H_FP)) && (h_q < H_W'(H_ACTIVE + H_FP + H_SYNC));
   assign vs_win  = (v_q >= V_W'(V_ACTIVE + V_FP)) && (v_q < V_W'(V_ACTIVE + V_FP + V_SYNC));
   assign latch   = pe && (h_q == '0) && (v_q == V_W'(V_ACTIVE + V_FP + V_SYNC));

   assign fifo_empty = (count_q == '0);
   // Words arriving with nothing outstanding (e.g. stale traffic after reset) are ignored.
   assign rsp_accept = rd_data_valid && (outstanding_q != '0);
   assign push       = rsp_accept && !latch && (drop_q == '0);
   assign pop        = pe && visible && !fifo_empty;
   assign req_fire   = (state_q == S_REQ) && rd_req_ready && !latch;

   assign fetch_more = (fetch_q < FETCH_W'(TOTAL_PIX));
   assign credit_sum = CRD_W'(count_q) + CRD_W'(outstanding_q) + CRD_W'(BURST_LEN);
   assign credit_ok  = (credit_sum <= CRD_W'(FIFO_DEPTH));

   always_comb begin
      div_d = pe ? '0 : div_q + 1'b1;
      h_d   = h_q;
      v_d   = v_q;
      if (pe) begin
         if (h_q == H_W'(H_TOTAL - 1)) begin
            h_d = '0;
            v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end
      end
   end

   always_comb begin
      de_d        = de_q;
      hsync_d     = hsync_q;
      vsync_d     = vsync_q;
      rgb_d       = rgb_q;
      underflow_d = underflow_q;
      if (pe) begin
         de_d    = visible;
         hsync_d = !hs_win;
         vsync_d = !vs_win;
         rgb_d   = pop ? fifo_mem_q[rd_ptr_q] : '0;
         if (visible && fifo_empty) begin
            underflow_d = 1'b1;
         end
      end
   end

   // At LATCH every word still in flight belongs to the old frame, including one landing this cycle.
   always_comb begin
      disp_sel_d    = latch ? ~flip : disp_sel_q;
      fetch_d       = fetch_q;
      outstanding_d = outstanding_q + (req_fire ? CNT_W'(BURST_LEN) : '0)
                      - (rsp_accept ? CNT_W'(1) : '0);
      drop_d        = drop_q;
      wr_ptr_d      = wr_ptr_q + (push ? PTR_W'(1) : '0);
      rd_ptr_d      = rd_ptr_q + (pop ? PTR_W'(1) : '0);
      count_d       = count_q + (push ? CNT_W'(1) : '0) - (pop ? CNT_W'(1) : '0);
      if (latch) begin
         fetch_d  = '0;
         drop_d   = outstanding_q - (rsp_accept ? CNT_W'(1) : '0);
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (req_fire) begin
            fetch_d = fetch_q + FETCH_W'(BURST_LEN);
         end
         if (rsp_accept && (drop_q != '0)) begin
            drop_d = drop_q - 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      unique case (state_q)
         S_IDLE: begin
            if (!latch && fetch_more && credit_ok) begin
               state_d    = S_REQ;
               req_addr_d = (disp_sel_q ? FB_BASE1 : FB_BASE0) + 32'(fetch_q);
            end
         end
         S_REQ: begin
            if (latch || rd_req_ready) begin
               state_d = S_IDLE;
            end
         end
      endcase
      req_valid_d = (state_d == S_REQ);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= S_IDLE;
         div_q         <= '0;
         h_q           <= '0;
         v_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         de_q          <= 1'b0;
         rgb_q         <= '0;
         underflow_q   <= 1'b0;
         disp_sel_q    <= 1'b0;
         fetch_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         req_valid_q   <= 1'b0;
         req_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         div_q         <= div_d;
         h_q           <= h_d;
         v_q           <= v_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         rgb_q         <= rgb_d;
         underflow_q   <= underflow_d;
         disp_sel_q    <= disp_sel_d;
         fetch_q       <= fetch_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         req_valid_q   <= req_valid_d;
         req_addr_q    <= req_addr_d;
      end
   end

   // Pixel storage carries no reset; validity is tracked by count/pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem_q[wr_ptr_q] <= rd_data[23:0];
      end
   end

   assert property (@(posedge clk) disable iff (!resetn)
                    !(push && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

   assign rd_req_valid = req_valid_q;
   assign rd_req_addr  = req_addr_q;
   assign rd_req_len   = 8'(BURST_LEN);
   assign hsync        = hsync_q;
   assign vsync        = vsync_q;
   assign de           = de_q;
   assign rgb          = rgb_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_frame_buffer_scanout.sv
// Directed bench for frame_buffer_scanout on a small raster (12x8 total, 8x4 visible, one pixel per clk).
// Memory returns {8'hA5, address[23:0]} so the pixel value names both buffer and index.
module tb_frame_buffer_scanout;

   localparam int HA = 8, HF = 1, HS = 1, HT = 12;
   localparam int VA = 4, VF = 1, VS = 1, VT = 8;
   localparam int FRAME = HT * VT;
   localparam int LATCH_OFS = (VA + VF + VS) * HT + 1;
   localparam logic [23:0] B0 = 24'h000000;
   localparam logic [23:0] B1 = 24'h008000;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        flip = 1'b0;
   logic        rd_req_valid, rd_req_ready, rd_data_valid;
   logic [31:0] rd_req_addr, rd_data;
   logic [7:0]  rd_req_len;
   logic        hsync, vsync, de, underflow;
   logic [23:0] rgb;

   int checks = 0;
   int failures = 0;
   int edges = 0;
   int acc_n = 0;
   int blk_lo = 363;
   int blk_hi = 457;

   typedef struct {
      int          due;
      logic [31:0] data;
   } word_t;
   word_t mq[$];

   typedef struct {
      int          edge_n;
      logic        de, hs, vs, px;
      logic [23:0] rgb;
      logic        uf;
   } vec_t;
   vec_t vec[$];

   always #5 clk = ~clk;

   frame_buffer_scanout #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_TOTAL(HT),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_TOTAL(VT),
      .PIX_DIV(1), .FIFO_DEPTH(64), .BURST_LEN(16),
      .FB_BASE0(32'h0000_0000), .FB_BASE1(32'h0000_8000)
   ) dut (
      .clk(clk), .resetn(resetn), .flip(flip),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
      .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data),
      .hsync(hsync), .vsync(vsync), .de(de), .rgb(rgb), .underflow(underflow)
   );

   always @(posedge clk) if (resetn) edges <= edges + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s @edge %0d: actual=%0h required=%0h", name, edges, act, exp);
      end
   endtask

   task automatic wait_edge(input int e);
      if (edges > e) begin
         failures++;
         $display("FAIL timeline: at edge %0d, required edge %0d", edges, e);
      end
      while (edges < e) @(negedge clk);
   endtask

   function automatic bit is_latch(input int n);
      return (n % FRAME) == LATCH_OFS;
   endfunction

   // Memory: in order, one word per cycle, 3-cycle latency except the sixth burst.
   initial begin
      int nxt, lat;
      word_t w;
      rd_req_ready  = 1'b0;
      rd_data_valid = 1'b0;
      rd_data       = 32'hDEAD_BEEF;
      forever begin
         @(negedge clk);
         nxt = edges + 1;
         rd_req_ready = rd_req_valid && !(nxt >= blk_lo && nxt < blk_hi);
         if (rd_req_ready && resetn && !is_latch(nxt)) begin
            lat = (acc_n == 5) ? 94 : 3;
            for (int j = 0; j < 16; j++) begin
               w.due  = nxt + lat;
               w.data = {8'hA5, 24'(rd_req_addr + 32'(j))};
               mq.push_back(w);
            end
            acc_n++;
         end
         if (mq.size() > 0 && mq[0].due <= nxt) begin
            w = mq.pop_front();
            rd_data_valid = 1'b1;
            rd_data       = w.data;
         end else begin
            rd_data_valid = 1'b0;
            rd_data       = 32'hDEAD_BEEF;
         end
      end
   end

   task automatic check_frame(input int f, input logic [23:0] base, input int nvalid);
      int npx = 0, nhs = 0, nvs = 0;
      logic [23:0] exp;
      for (int e = FRAME * f + 1; e <= FRAME * f + FRAME; e++) begin
         wait_edge(e);
         if (de === 1'b1) begin
            exp = (npx < nvalid) ? base + 24'(npx) : 24'h0;
            chk($sformatf("pixel f%0d i%0d", f, npx), 32'(rgb), 32'(exp));
            npx++;
         end else begin
            chk($sformatf("rgb_blank f%0d", f), 32'(rgb), 32'h0);
         end
         if (hsync === 1'b0) nhs++;
         if (vsync === 1'b0) nvs++;
      end
      chk($sformatf("de_count f%0d", f), 32'(npx), 32'(VA * HA));
      chk($sformatf("hsync_low f%0d", f), 32'(nhs), 32'(VT * HS));
      chk($sformatf("vsync_low f%0d", f), 32'(nvs), 32'(VS * HT));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at edge %0d", edges);
      $fatal(1, "watchdog");
   end

   initial begin
      //                edge de hs vs px rgb     uf
      vec.push_back('{  1, 1, 1, 1, 1, 24'h00, 1});
      vec.push_back('{  8, 1, 1, 1, 1, 24'h02, 1});
      vec.push_back('{  9, 0, 1, 1, 1, 24'h00, 1});
      vec.push_back('{ 10, 0, 0, 1, 0, 24'h00, 1});
      vec.push_back('{ 11, 0, 1, 1, 0, 24'h00, 1});
      vec.push_back('{ 12, 0, 1, 1, 0, 24'h00, 1});
      vec.push_back('{ 13, 1, 1, 1, 1, 24'h03, 1});
      vec.push_back('{ 40, 1, 1, 1, 1, 24'h16, 1});
      vec.push_back('{ 49, 0, 1, 1, 1, 24'h00, 1});
      vec.push_back('{ 58, 0, 0, 1, 0, 24'h00, 1});
      vec.push_back('{ 61, 0, 1, 0, 0, 24'h00, 1});
      vec.push_back('{ 70, 0, 0, 0, 0, 24'h00, 1});
      vec.push_back('{ 72, 0, 1, 0, 0, 24'h00, 1});
      vec.push_back('{ 73, 0, 1, 1, 0, 24'h00, 1});

      repeat (3) @(negedge clk);
      chk("rst_hsync", 32'(hsync), 32'h1);
      chk("rst_vsync", 32'(vsync), 32'h1);
      chk("rst_de", 32'(de), 32'h0);
      chk("rst_rgb", 32'(rgb), 32'h0);
      chk("rst_req_valid", 32'(rd_req_valid), 32'h0);
      chk("rst_underflow", 32'(underflow), 32'h0);
      resetn = 1'b1;

      for (int i = 0; i < vec.size(); i++) begin
         wait_edge(vec[i].edge_n);
         chk($sformatf("de@%0d", vec[i].edge_n), 32'(de), 32'(vec[i].de));
         chk($sformatf("hsync@%0d", vec[i].edge_n), 32'(hsync), 32'(vec[i].hs));
         chk($sformatf("vsync@%0d", vec[i].edge_n), 32'(vsync), 32'(vec[i].vs));
         if (vec[i].px) begin
            chk($sformatf("rgb@%0d", vec[i].edge_n), 32'(rgb), 32'(vec[i].rgb));
            chk($sformatf("underflow@%0d", vec[i].edge_n), 32'(underflow), 32'(vec[i].uf));
         end
      end

      wait_edge(74);
      chk("first_req_valid", 32'(rd_req_valid), 32'h1);
      chk("first_req_addr", rd_req_addr, 32'h0000_8000);
      chk("first_req_len", 32'(rd_req_len), 32'd16);

      fork
         check_frame(1, B1, 32);
         begin
            wait_edge(100);
            flip = 1'b1;
         end
      join

      fork
         check_frame(2, B0, 16);
         begin
            wait_edge(255);
            chk("vsync_low_at_flip", 32'(vsync), 32'h0);
            flip = 1'b0;
         end
      join

      fork
         begin
            check_frame(3, B1, 32);
            check_frame(4, B1, 0);
         end
         begin
            wait_edge(362);
            chk("stall_req_valid", 32'(rd_req_valid), 32'h1);
            chk("stall_req_addr", rd_req_addr, 32'h0000_8000);
            for (int e = 363; e < 413; e++) begin
               wait_edge(e);
               chk("stall_valid_stable", 32'(rd_req_valid), 32'h1);
               chk("stall_addr_stable", rd_req_addr, 32'h0000_8000);
            end
            wait_edge(456);
            chk("pending_before_latch", 32'(rd_req_valid), 32'h1);
            wait_edge(457);
            chk("withdrawn_at_latch", 32'(rd_req_valid), 32'h0);
            wait_edge(458);
            chk("req_after_latch_valid", 32'(rd_req_valid), 32'h1);
            chk("req_after_latch_addr", rd_req_addr, 32'h0000_8000);
         end
      join

      check_frame(5, B1, 32);
      check_frame(6, B1, 32);
      chk("underflow_sticky", 32'(underflow), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
